fp_addsub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the execute stage's FP unit. It accepts operand pairs with a per-transaction add/sub select and produces normalised, rounded results three cycles later. A valid/ready handshake with full-pipeline stall lets it sit behind the ID/EX register and ahead of the FP writeback mux. Unlike the previous combinational single-precision adder, it supports generic exponent and mantissa widths, IEEE special values, status flags and (optionally) round-to-nearest-even.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_lzc.sv | 21 ++
 rtl/fp_addsub_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constant builders for the parametrised FP add/sub pipeline.
// The optional feature macro FP_ADDSUB_RNE_EN is consumed by fp_addsub_pipe.
package fp_pkg;

  localparam int FP_MAX_W = 64;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int fp_sig_w(input int man_w);
    return man_w + 4;
  endfunction

  // Words are built at FP_MAX_W and narrowed by the caller to 1+exp_w+man_w bits.
  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < FP_MAX_W; i++) begin
      if (i >= man_w && i < man_w + exp_w) v[i] = 1'b1;
      else if (i == man_w + exp_w)         v[i] = sign;
      else                                 v[i] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(1'b0, exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_max_finite(input logic sign, input int exp_w, input int man_w);
    return (fp_inf(sign, exp_w, man_w) & ~(64'd1 << man_w)) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero vector yields W.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int W     = 27,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     i_vec,
  output logic [CNT_W-1:0] o_cnt
);

  // Scan upward so the highest set bit determines the count.
  always_comb begin
    o_cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) o_cnt = CNT_W'(W - 1 - i);
      else          o_cnt = o_cnt;
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined FP adder/subtractor (align, add, normalise/round) with
// valid/ready stall. Define FP_ADDSUB_RNE_EN for round-to-nearest-even; default truncates.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = fp_sig_w(MAN_W);
  localparam int SUM_W = SIG_W + 1;
  localparam int LZ_W  = $clog2(SIG_W + 1);
  localparam int EW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
  localparam int SAT   = MAN_W + 3;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpk_t;

  function automatic fp_unpk_t unpack(input logic [W-1:0] x, input logic flip);
    fp_unpk_t u;
    u.sign    = x[W-1] ^ flip;
    u.exp     = x[W-2 -: EXP_W];
    u.sig     = {1'b1, x[MAN_W-1:0], 3'b000};
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == '1) && (x[MAN_W-1:0] == '0);
    u.is_nan  = (u.exp == '1) && (x[MAN_W-1:0] != '0);
    return u;
  endfunction

  fp_unpk_t         w_ua, w_ub;
  logic [SIG_W-1:0] w_a_sig, w_b_sig, w_big_sig, w_sml_sig, w_sml_al;
  logic [EXP_W-1:0] w_big_exp, w_sml_exp;
  logic             w_big_sign, w_nan, w_inf, w_inf_sign;
  logic [31:0]      w_diff, w_shamt;
  logic [2*SIG_W-1:0] w_sh;

  logic             r_s1_valid, r_s1_sign, r_s1_eff_sub, r_s1_nan, r_s1_inf, r_s1_inf_sign;
  logic [EXP_W-1:0] r_s1_exp;
  logic [SIG_W-1:0] r_s1_big, r_s1_sml;

  logic             r_s2_valid, r_s2_sign, r_s2_eff_sub, r_s2_nan, r_s2_inf, r_s2_inf_sign;
  logic [EXP_W-1:0] r_s2_exp;
  logic [SUM_W-1:0] r_s2_sum, w_sum;

  logic [LZ_W-1:0]        w_lz;
  logic [SIG_W-1:0]       w_norm;
  logic signed [EW-1:0]   w_exp, w_exp_r;
  logic [MAN_W:0]         w_frac_inc;
  logic                   w_rnd_up;
  logic [W-1:0]           w_res;
  fp_flags_t              w_flg;

  logic                   r_out_valid;
  logic [W-1:0]           r_result;
  fp_flags_t              r_flags;

  assign in_ready  = !r_out_valid | out_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // Align: unpack, order by magnitude, shift the smaller significand with sticky.
  always_comb begin
    w_ua    = unpack(a, 1'b0);
    w_ub    = unpack(b, op_sub);
    w_a_sig = w_ua.is_zero ? '0 : w_ua.sig;
    w_b_sig = w_ub.is_zero ? '0 : w_ub.sig;
    if ({w_ub.exp, w_b_sig} > {w_ua.exp, w_a_sig}) begin
      w_big_sign = w_ub.sign;
      w_big_exp  = w_ub.exp;
      w_big_sig  = w_b_sig;
      w_sml_exp  = w_ua.exp;
      w_sml_sig  = w_a_sig;
    end else begin
      w_big_sign = w_ua.sign;
      w_big_exp  = w_ua.exp;
      w_big_sig  = w_a_sig;
      w_sml_exp  = w_ub.exp;
      w_sml_sig  = w_b_sig;
    end
    w_diff     = 32'(w_big_exp) - 32'(w_sml_exp);
    w_shamt    = (w_diff > 32'(SAT)) ? 32'(SAT) : w_diff;
    w_sh       = {w_sml_sig, {SIG_W{1'b0}}} >> w_shamt;
    w_sml_al   = w_sh[2*SIG_W-1:SIG_W] | {{(SIG_W-1){1'b0}}, |w_sh[SIG_W-1:0]};
    w_nan      = w_ua.is_nan | w_ub.is_nan | (w_ua.is_inf & w_ub.is_inf & (w_ua.sign ^ w_ub.sign));
    w_inf      = w_ua.is_inf | w_ub.is_inf;
    w_inf_sign = w_ua.is_inf ? w_ua.sign : w_ub.sign;
  end

  // Add: magnitudes are ordered, so subtraction never goes negative.
  always_comb begin
    if (r_s1_eff_sub) w_sum = {1'b0, r_s1_big} - {1'b0, r_s1_sml};
    else              w_sum = {1'b0, r_s1_big} + {1'b0, r_s1_sml};
  end

  fp_lzc #(.W(SIG_W), .CNT_W(LZ_W)) u_lzc (
    .i_vec (r_s2_sum[SIG_W-1:0]),
    .o_cnt (w_lz)
  );

  // Normalise, round and resolve specials; a cleared hidden bit means the sum is exactly zero.
  always_comb begin
    w_norm = '0;
    w_exp  = '0;
    if (r_s2_sum[SIG_W]) begin
      w_norm = r_s2_sum[SIG_W:1] | {{(SIG_W-1){1'b0}}, r_s2_sum[0]};
      w_exp  = EW'(r_s2_exp) + EW'(1'b1);
    end else begin
      w_norm = r_s2_sum[SIG_W-1:0] << w_lz;
      w_exp  = EW'(r_s2_exp) - EW'(w_lz);
    end
`ifdef FP_ADDSUB_RNE_EN
    w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
`else
    w_rnd_up = 1'b0;
`endif
    w_frac_inc = {1'b0, w_norm[SIG_W-2:3]} + (MAN_W+1)'(w_rnd_up);
    w_exp_r    = w_exp + EW'(w_frac_inc[MAN_W]);
    w_res      = '0;
    w_flg      = '0;
    if (r_s2_nan) begin
      w_res         = W'(fp_qnan(EXP_W, MAN_W));
      w_flg.invalid = 1'b1;
    end else if (r_s2_inf) begin
      w_res = W'(fp_inf(r_s2_inf_sign, EXP_W, MAN_W));
    end else if (!w_norm[SIG_W-1]) begin
      w_res = {r_s2_sign & ~r_s2_eff_sub, {(W-1){1'b0}}};
    end else if (w_exp_r >= EXP_MAX) begin
`ifdef FP_ADDSUB_RNE_EN
      w_res = W'(fp_inf(r_s2_sign, EXP_W, MAN_W));
`else
      w_res = W'(fp_max_finite(r_s2_sign, EXP_W, MAN_W));
`endif
      w_flg.overflow = 1'b1;
      w_flg.inexact  = 1'b1;
    end else if (w_exp_r <= EXP_ZERO) begin
      w_res           = {r_s2_sign, {(W-1){1'b0}}};
      w_flg.underflow = 1'b1;
      w_flg.inexact   = 1'b1;
    end else begin
      w_res         = {r_s2_sign, w_exp_r[EXP_W-1:0], w_frac_inc[MAN_W-1:0]};
      w_flg.inexact = |w_norm[2:0];
    end
  end

  // Pipeline registers: every stage advances together whenever the output can move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_eff_sub  <= 1'b0;
      r_s1_nan      <= 1'b0;
      r_s1_inf      <= 1'b0;
      r_s1_inf_sign <= 1'b0;
      r_s1_exp      <= '0;
      r_s1_big      <= '0;
      r_s1_sml      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_sign     <= 1'b0;
      r_s2_eff_sub  <= 1'b0;
      r_s2_nan      <= 1'b0;
      r_s2_inf      <= 1'b0;
      r_s2_inf_sign <= 1'b0;
      r_s2_exp      <= '0;
      r_s2_sum      <= '0;
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_flags       <= '0;
    end else if (in_ready) begin
      r_s1_valid    <= in_valid;
      r_s1_sign     <= w_big_sign;
      r_s1_eff_sub  <= w_ua.sign ^ w_ub.sign;
      r_s1_nan      <= w_nan;
      r_s1_inf      <= w_inf;
      r_s1_inf_sign <= w_inf_sign;
      r_s1_exp      <= w_big_exp;
      r_s1_big      <= w_big_sig;
      r_s1_sml      <= w_sml_al;
      r_s2_valid    <= r_s1_valid;
      r_s2_sign     <= r_s1_sign;
      r_s2_eff_sub  <= r_s1_eff_sub;
      r_s2_nan      <= r_s1_nan;
      r_s2_inf      <= r_s1_inf;
      r_s2_inf_sign <= r_s1_inf_sign;
      r_s2_exp      <= r_s1_exp;
      r_s2_sum      <= w_sum;
      r_out_valid   <= r_s2_valid;
      r_result      <= r_s2_valid ? w_res : r_result;
      r_flags       <= r_s2_valid ? w_flg : r_flags;
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe at single precision; expectations
// for rounding/overflow follow FP_ADDSUB_RNE_EN when it is defined.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef FP_ADDSUB_RNE_EN
  localparam logic [31:0] EXP_OVF = 32'h7F80_0000;
  localparam logic [31:0] EXP_RND = 32'h3F80_0001;
`else
  localparam logic [31:0] EXP_OVF = 32'h7F7F_FFFF;
  localparam logic [31:0] EXP_RND = 32'h3F80_0000;
`endif

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Push one operation into an idle pipe and wait (bounded) for its result.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       output logic [31:0] res, output logic [3:0] flg, output int lat);
    @(negedge clk);
    a = ta; b = tb; op_sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    flg = flags;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", result); end
    n_cmp++; if (flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %h expected 0", flags); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add;
    logic [31:0] r; logic [3:0] f; int lat;
    do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, r, f, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL add_latency: got %0d expected 3", lat); end
    n_cmp++; if (r !== 32'h4000_0000) begin n_err++; $display("FAIL add_1p1: got %h expected 40000000", r); end
    n_cmp++; if (f !== 4'h0) begin n_err++; $display("FAIL add_1p1_flags: got %h expected 0", f); end
  endtask

  task automatic test_sub;
    logic [31:0] r; logic [3:0] f; int lat;
    do_op(32'h4040_0000, 32'h3F80_0000, 1'b1, r, f, lat);
    n_cmp++; if (r !== 32'h4000_0000 || f !== 4'h0) begin n_err++; $display("FAIL sub_3m1: got %h/%h expected 40000000/0", r, f); end
    do_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, r, f, lat);
    n_cmp++; if (r !== 32'h0000_0000 || f !== 4'h0) begin n_err++; $display("FAIL sub_1m1: got %h/%h expected 00000000/0", r, f); end
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, r, f, lat);
    n_cmp++; if (r !== 32'h8000_0000 || f !== 4'h0) begin n_err++; $display("FAIL negzero_sum: got %h/%h expected 80000000/0", r, f); end
    do_op(32'h3F80_0000, 32'h4000_0000, 1'b1, r, f, lat);
    n_cmp++; if (r !== 32'hBF80_0000 || f !== 4'h0) begin n_err++; $display("FAIL sub_1m2: got %h/%h expected bf800000/0", r, f); end
  endtask

  task automatic test_overflow;
    logic [31:0] r; logic [3:0] f; int lat;
    do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, r, f, lat);
    n_cmp++; if (r !== EXP_OVF) begin n_err++; $display("FAIL ovf_result: got %h expected %h", r, EXP_OVF); end
    n_cmp++; if (f !== 4'b0101) begin n_err++; $display("FAIL ovf_flags: got %b expected 0101", f); end
  endtask

  task automatic test_rounding;
    logic [31:0] r; logic [3:0] f; int lat;
    do_op(32'h3F80_0000, 32'h33C0_0000, 1'b0, r, f, lat);
    n_cmp++; if (r !== EXP_RND) begin n_err++; $display("FAIL round_above_half: got %h expected %h", r, EXP_RND); end
    n_cmp++; if (f !== 4'b0001) begin n_err++; $display("FAIL round_above_half_flags: got %b expected 0001", f); end
    do_op(32'h3F80_0000, 32'h3380_0000, 1'b0, r, f, lat);
    n_cmp++; if (r !== 32'h3F80_0000) begin n_err++; $display("FAIL round_tie_even: got %h expected 3f800000", r); end
    n_cmp++; if (f !== 4'b0001) begin n_err++; $display("FAIL round_tie_flags: got %b expected 0001", f); end
  endtask

  task automatic test_specials;
    logic [31:0] r; logic [3:0] f; int lat;
    do_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, r, f, lat);
    n_cmp++; if (r !== 32'h7FC0_0000 || f !== 4'b1000) begin n_err++; $display("FAIL inf_minus_inf: got %h/%b expected 7fc00000/1000", r, f); end
    do_op(32'h7F80_0001, 32'h3F80_0000, 1'b0, r, f, lat);
    n_cmp++; if (r !== 32'h7FC0_0000 || f !== 4'b1000) begin n_err++; $display("FAIL nan_operand: got %h/%b expected 7fc00000/1000", r, f); end
    do_op(32'h3F80_0000, 32'h7F80_0000, 1'b1, r, f, lat);
    n_cmp++; if (r !== 32'hFF80_0000 || f !== 4'b0000) begin n_err++; $display("FAIL finite_minus_inf: got %h/%b expected ff800000/0000", r, f); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] ve [10];
    logic        vs [10];
    int          sent, rcvd, cyc, guard;
    logic        acc, held_v;
    logic [31:0] held_r;
    va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
           32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'hBF800000};
    vb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
           32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'hBF800000};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ve = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40800000,
           32'h3F800000, 32'h40400000, 32'hBF800000, 32'h3F800000, 32'hC0000000};
    sent = 0; rcvd = 0; cyc = 0; guard = 0; held_v = 1'b0; held_r = '0;
    fork
      begin
        while (sent < 10 && guard < 200) begin
          @(negedge clk);
          guard++;
          a = va[sent]; b = vb[sent]; op_sub = vs[sent]; in_valid = 1'b1;
          #1;
          acc = in_ready;
          @(posedge clk);
          if (acc) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        while (rcvd < 10 && cyc < 100) begin
          @(negedge clk);
          cyc++;
          out_ready = !(cyc >= 4 && cyc < 8);
          #2;
          if (held_v) begin
            n_cmp++;
            if (result !== held_r) begin n_err++; $display("FAIL stall_hold: got %h expected %h", result, held_r); end
          end
          held_v = out_valid && !out_ready;
          held_r = result;
          if (out_valid && out_ready) begin
            n_cmp++;
            if (result !== ve[rcvd] || flags !== 4'h0) begin
              n_err++; $display("FAIL stream_%0d: got %h/%h expected %h/0", rcvd, result, flags, ve[rcvd]);
            end
            rcvd++;
          end
        end
        out_ready = 1'b1;
      end
    join
    n_cmp++; if (rcvd !== 10) begin n_err++; $display("FAIL stream_count: got %0d expected 10", rcvd); end
    n_cmp++; if (sent !== 10) begin n_err++; $display("FAIL stream_sent: got %0d expected 10", sent); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_extra: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_flush;
    int          seen;
    logic [31:0] r; logic [3:0] f; int lat;
    seen = 0;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL reset_flush: got %0d outputs expected 0", seen); end
    do_op(32'h4000_0000, 32'h3F80_0000, 1'b0, r, f, lat);
    n_cmp++; if (r !== 32'h4040_0000 || lat !== 3) begin n_err++; $display("FAIL after_reset: got %h lat %0d expected 40400000 lat 3", r, lat); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_overflow;
    test_rounding;
    test_specials;
    test_back_to_back;
    test_reset_flush;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
